ex_alu_unit: RTL and testbench
==============================

// Module: ex_alu_unit
// PURPOSE
//  Execute-stage ALU. Consumes the 3-bit ALUCtrl code from ALU_Control plus the two EX
//  operands, and produces a registered result for the EX/MEM boundary.
//  AND/OR/ADD/SUB complete in one clock. MUL runs as an iterative shift-add over WIDTH
//  clocks and holds the upstream pipeline with stall_o.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; also the MUL iteration count
//  CNT_W   5    iteration counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//  clk_i       input   1      clock; all state updates on the rising edge
//  rst_i       input   1      reset, synchronous, active-low
//  valid_i     input   1      an operation is presented this cycle
//  ALUCtrl_i   input   3      000 AND, 001 OR, 010 ADD, 110 SUB, 111 MUL
//  data1_i     input   WIDTH  operand A
//  data2_i     input   WIDTH  operand B
//  result_o    output  WIDTH  registered result
//  zero_o      output  1      registered; 1 when the same-edge result is all zeros
//  valid_o     output  1      one-cycle pulse; result_o/zero_o are new this cycle
//  stall_o     output  1      combinational; upstream must hold the EX inputs when high
// BEHAVIOUR
//  Reset (rst_i==0 at an edge):
//   - state=IDLE, result_o=0, zero_o=1, valid_o=0, counter=0, partial regs=0.
//   - stall_o is forced 0 while rst_i is low.
//   - A reset mid-MUL abandons the operation; no valid_o is produced for it.
//  States: IDLE, BUSY.
//  IDLE, valid_i=0:
//   - valid_o=0 next cycle; result_o/zero_o hold their values.
//  IDLE, valid_i=1, non-MUL op:
//   - At the edge, result_o=f(A,B) and valid_o=1; latency is 1 clock.
//   - stall_o=0. Back-to-back ops are accepted every cycle.
//  Arithmetic:
//   - ADD/SUB are modulo 2**WIDTH (SUB = A-B); carry/borrow is discarded.
//   - AND/OR are bitwise.
//   - Codes 011/100/101 execute as ADD.
//  IDLE, valid_i=1, ALUCtrl_i=111 (MUL):
//   - stall_o=1 combinationally in this accept cycle.
//   - At the edge: mcand=A, mplier=B, acc=0, count=0, state=BUSY.
//   - valid_o=0; result_o holds.
//  BUSY, each edge:
//   - if mplier[0], acc=acc+mcand; then mcand<<=1, mplier>>=1, count++.
//   - All inputs are ignored while BUSY (upstream holds them stable).
//  BUSY stall rule:
//   - stall_o=1 while count != WIDTH-1.
//   - stall_o=0 in the final BUSY cycle (count==WIDTH-1), so upstream advances on the same edge that finishes the MUL.
//  Final BUSY edge (count==WIDTH-1):
//   - result_o = low WIDTH bits of A*B (including the last partial sum).
//   - zero_o updated; valid_o=1; state=IDLE.
//  MUL timing totals:
//   - Accept edge plus WIDTH iteration edges.
//   - valid_o is high WIDTH+1 cycles after the accept cycle.
//   - stall_o is high exactly WIDTH consecutive cycles.
//  MUL result semantics:
//   - The low-WIDTH product is identical for signed and unsigned operands; no sign handling.
//   - Upper product bits are discarded; no overflow flag.
//  Next op after MUL: the op presented in the cycle after the final edge is accepted normally (IDLE).
//  zero_o always reflects result_o and is registered on the same edge.
// TESTING
//  - ADD A=5, B=7, valid_i=1 -> next cycle result_o=12, zero_o=0, valid_o=1, stall_o=0.
//  - SUB 3-5 -> 0xFFFFFFFE, zero_o=0. Then SUB 9-9 on the next cycle -> 0, zero_o=1.
//    valid_o is high for both consecutive cycles.
//  - MUL 0xFFFFFFFF*3 -> stall_o high exactly 32 cycles from accept.
//    valid_o pulses once, 33 cycles after accept, with result_o=0xFFFFFFFD.
//    Inputs toggled during BUSY have no effect.
//  - MUL 6*7 immediately followed by AND 0xF0F0&0xFF00:
//    - result 42 arrives, then AND result 0xF000 one cycle later.
//    - The MUL is not re-accepted.
//  - Reset at BUSY cycle 10 of a MUL -> next cycle: IDLE, result_o=0, zero_o=1, valid_o=0, stall_o=0.
//    No MUL result ever appears.
//  - ALUCtrl_i=3'b100, A=2, B=2 -> result_o=4. valid_i=0 for 3 cycles -> valid_o=0, result_o holds 4.

Source files
------------

// File: rtl/ex_alu_unit_if.sv
// Execute-stage ALU bus: operation request from the pipeline, registered
// result and valid pulse back, plus the combinational stall.
interface ex_alu_unit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             valid_o;
  logic             stall_o;

  // Upstream pipeline side: presents operations, honours stall
  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  result_o, zero_o, valid_o, stall_o
  );

  // ALU side: consumes operations, produces results
  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output result_o, zero_o, valid_o, stall_o
  );
endinterface

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU. AND/OR/ADD/SUB finish in one clock; MUL is an iterative
// shift-add over WIDTH clocks that holds the upstream pipeline via stall_o.
module ex_alu_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ex_alu_unit_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [2:0]       OP_AND = 3'b000;
  localparam logic [2:0]       OP_OR  = 3'b001;
  localparam logic [2:0]       OP_SUB = 3'b110;
  localparam logic [2:0]       OP_MUL = 3'b111;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic             is_mul;
  logic             stall;

  // Single-cycle datapath; unused codes (011/100/101) fall through to ADD
  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl_i)
      OP_AND:  alu_res = bus.data1_i & bus.data2_i;
      OP_OR:   alu_res = bus.data1_i | bus.data2_i;
      OP_SUB:  alu_res = bus.data1_i - bus.data2_i;
      default: alu_res = bus.data1_i + bus.data2_i;
    endcase
  end

  assign is_mul   = (bus.ALUCtrl_i == OP_MUL);
  // Partial sum including the current multiplier bit
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Stall covers the MUL accept cycle and every BUSY cycle but the last,
  // so upstream advances on the same edge that completes the product
  always_comb begin
    stall = 1'b0;
    if (rst_i) begin
      if (state_q == S_IDLE)
        stall = bus.valid_i && is_mul;
      else
        stall = (count_q != LAST);
    end
  end

  // Next-state and datapath update for the IDLE/BUSY controller
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          if (is_mul) begin
            mcand_d  = bus.data1_i;
            mplier_d = bus.data2_i;
            acc_d    = '0;
            count_d  = '0;
            state_d  = S_BUSY;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          valid_d  = 1'b1;
          count_d  = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.valid_o  = valid_q;
  assign bus.stall_o  = stall;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: the driver pushes reference results,
// an independent monitor pops and checks them whenever valid_o is seen.
module tb_ex_alu_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    int           cyc;
    logic [2:0]   op;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  ex_alu_unit_if #(.WIDTH(W)) bus ();

  ex_alu_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model straight from the operation table
  function automatic logic [W-1:0] ref_alu(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b110:  return a - b;
      3'b111:  return a * b;
      default: return a + b;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid_o must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: result 0x%08h with no pending op (cycle %0d)",
                 bus.result_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result_o, e.res);
        check("zero", W'(bus.zero_o), W'(e.zero));
        check("latency_cycle", W'(cyc), W'(e.cyc));
        $display("[TB] op=%03b result=0x%08h zero=%0b cycle=%0d", e.op, bus.result_o,
                 bus.zero_o, cyc);
      end
    end
  end

  task automatic idle();
    bus.valid_i   = 1'b0;
    bus.ALUCtrl_i = 3'($urandom_range(0, 7));
    bus.data1_i   = $urandom;
    bus.data2_i   = $urandom;
  endtask

  // Present one op, hold it until stall_o drops, optionally scrambling the
  // inputs while the MUL is busy (they must be ignored)
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit toggle);
    exp_t e;
    int   stalls = 0;
    bit   done = 0;
    logic s;
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    e.res  = ref_alu(op, a, b);
    e.zero = (e.res == '0);
    e.cyc  = cyc + ((op == 3'b111) ? W + 1 : 1);
    e.op   = op;
    sb.push_back(e);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      s = bus.stall_o;
      if (s) stalls++;
      @(posedge clk);
      #1;
      if (!s) done = 1;
      else if (toggle) begin
        bus.valid_i   = $urandom_range(0, 1);
        bus.ALUCtrl_i = 3'($urandom_range(0, 7));
        bus.data1_i   = $urandom;
        bus.data2_i   = $urandom;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL stall_timeout: stall_o never dropped for op %03b", op);
    end
    check("stall_cycles", W'(stalls), (op == 3'b111) ? W'(W) : W'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a MUL presented: stall must stay low, outputs at reset values
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b111;
    bus.data1_i   = 32'd9;
    bus.data2_i   = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_zero", W'(bus.zero_o), W'(1));
    check("rst_valid", W'(bus.valid_o), W'(0));
    check("rst_stall", W'(bus.stall_o), W'(0));
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    issue(3'b010, 32'd5, 32'd7, 0);
    issue(3'b110, 32'd3, 32'd5, 0);
    issue(3'b110, 32'd9, 32'd9, 0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    issue(3'b111, 32'hFFFF_FFFF, 32'd3, 1);
    idle();
    repeat (2) @(posedge clk);
    #1;
    issue(3'b111, 32'd6, 32'd7, 0);
    issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 0);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a MUL: abandoned, no result may appear
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'b111;
    bus.data1_i   = 32'd1234;
    bus.data2_i   = 32'd5678;
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_stall_low", W'(bus.stall_o), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    check("midrst_result", bus.result_o, 32'd0);
    check("midrst_zero", W'(bus.zero_o), W'(1));
    check("midrst_valid", W'(bus.valid_o), W'(0));
    check("midrst_stall", W'(bus.stall_o), W'(0));
    repeat (40) @(posedge clk);
    #1;

    // Aliased ADD code, then idle cycles must hold the result
    issue(3'b100, 32'd2, 32'd2, 0);
    idle();
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
      check("hold_result", bus.result_o, 32'd4);
    end

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      int          r;
      logic [2:0]  op;
      logic [W-1:0] a, b;
      r  = $urandom_range(0, 9);
      op = (r > 7) ? 3'b111 : 3'(r);
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'(a[7:0]);
      issue(op, a, b, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle();

    // Drain the scoreboard
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
